// File: rtl/hazard_ctrl_if.sv
// Handshake bundle between the pipeline datapath and hazard_ctrl.
// HAZARD_PERF_EN adds the stall/flush performance counter outputs.
interface hazard_ctrl_if #(parameter int REG_BITS = 4);
  logic [REG_BITS-1:0] ra1_d, ra2_d, ra3_d;
  logic                use1_d, use2_d, use3_d;
  logic [REG_BITS-1:0] ra1_e, ra2_e, ra3_e;
  logic [REG_BITS-1:0] wa_e, wa_m, wa_w;
  logic                reg_write_e, reg_write_m, reg_write_w;
  logic                mem_reg_e;
  logic                branch_taken_m;
  logic                mem_access_m;
  logic                mem_ready;
  logic [1:0]          fwd_a_e, fwd_b_e, fwd_c_e;
  logic                stall_f, stall_d, stall_e, stall_m;
  logic                flush_d, flush_e, flush_w;
`ifdef HAZARD_PERF_EN
  logic [15:0]         stall_count, flush_count;
`endif

  modport master (
    output ra1_d, ra2_d, ra3_d, use1_d, use2_d, use3_d,
    output ra1_e, ra2_e, ra3_e, wa_e, wa_m, wa_w,
    output reg_write_e, reg_write_m, reg_write_w,
    output mem_reg_e, branch_taken_m, mem_access_m, mem_ready,
`ifdef HAZARD_PERF_EN
    input  stall_count, flush_count,
`endif
    input  fwd_a_e, fwd_b_e, fwd_c_e,
    input  stall_f, stall_d, stall_e, stall_m,
    input  flush_d, flush_e, flush_w
  );

  modport slave (
    input  ra1_d, ra2_d, ra3_d, use1_d, use2_d, use3_d,
    input  ra1_e, ra2_e, ra3_e, wa_e, wa_m, wa_w,
    input  reg_write_e, reg_write_m, reg_write_w,
    input  mem_reg_e, branch_taken_m, mem_access_m, mem_ready,
`ifdef HAZARD_PERF_EN
    output stall_count, flush_count,
`endif
    output fwd_a_e, fwd_b_e, fwd_c_e,
    output stall_f, stall_d, stall_e, stall_m,
    output flush_d, flush_e, flush_w
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller beside the execute stage: forwarding, load-use, branch flush, memory wait.
// HAZARD_PERF_EN adds saturating stall_count/flush_count.
// state   | meaning
// RUN     | normal issue; forwarding and load-use active
// MEMWAIT | M-stage access pending, pipe frozen until mem_ready
// BFLUSH  | extra flush cycles after a taken branch, fcnt counts down
module hazard_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int REG_BITS     = 4
) (
  input logic         clk,
  input logic         rst,
  hazard_ctrl_if.slave hz
);
  typedef enum logic [1:0] {RUN, MEMWAIT, BFLUSH} state_t;

  localparam logic [2:0] FCNT_LOAD = 3'(FLUSH_CYCLES - 1);

  state_t     state, state_nxt;
  logic [2:0] fcnt, fcnt_nxt;
  logic       ldhaz, mem_wait, hold;
  logic [1:0] fwd_a, fwd_b, fwd_c;
  logic       stall_f, stall_d, stall_e, stall_m;
  logic       flush_d, flush_e, flush_w;

  function automatic logic [1:0] fwd_sel(
    input logic [REG_BITS-1:0] ra,
    input logic                wr_m,
    input logic [REG_BITS-1:0] wm,
    input logic                wr_w,
    input logic [REG_BITS-1:0] ww
  );
    if (wr_m && wm == ra)      return 2'b10;
    else if (wr_w && ww == ra) return 2'b01;
    else                       return 2'b00;
  endfunction

  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    fwd_c = 2'b00;
    if (!rst) begin
      fwd_a = fwd_sel(hz.ra1_e, hz.reg_write_m, hz.wa_m, hz.reg_write_w, hz.wa_w);
      fwd_b = fwd_sel(hz.ra2_e, hz.reg_write_m, hz.wa_m, hz.reg_write_w, hz.wa_w);
      fwd_c = fwd_sel(hz.ra3_e, hz.reg_write_m, hz.wa_m, hz.reg_write_w, hz.wa_w);
    end
  end

  assign ldhaz = hz.mem_reg_e && hz.reg_write_e &&
                 ((hz.use1_d && hz.ra1_d == hz.wa_e) ||
                  (hz.use2_d && hz.ra2_d == hz.wa_e) ||
                  (hz.use3_d && hz.ra3_d == hz.wa_e));
  assign mem_wait = hz.mem_access_m && !hz.mem_ready;
  // once waiting, only mem_ready releases the pipe
  assign hold = (state == MEMWAIT) ? !hz.mem_ready : mem_wait;

  always_comb begin
    state_nxt = state;
    fcnt_nxt  = fcnt;
    stall_f = 1'b0; stall_d = 1'b0; stall_e = 1'b0; stall_m = 1'b0;
    flush_d = 1'b0; flush_e = 1'b0; flush_w = 1'b0;
    unique case (state)
      RUN, MEMWAIT: begin
        if (hold) begin
          {stall_f, stall_d, stall_e, stall_m, flush_w} = 5'b11111;
          state_nxt = MEMWAIT;
        end else if (hz.branch_taken_m) begin
          flush_d = 1'b1;
          flush_e = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_nxt = BFLUSH;
            fcnt_nxt  = FCNT_LOAD;
          end else begin
            state_nxt = RUN;
          end
        end else begin
          state_nxt = RUN;
          if (ldhaz) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
          end
        end
      end
      BFLUSH: begin
        if (mem_wait) begin
          {stall_f, stall_d, stall_e, stall_m, flush_w} = 5'b11111;
          state_nxt = MEMWAIT;
          fcnt_nxt  = 3'd0;
        end else begin
          flush_d = 1'b1;
          flush_e = 1'b1;
          if (hz.branch_taken_m && FLUSH_CYCLES > 1) begin
            fcnt_nxt = FCNT_LOAD;
          end else if (hz.branch_taken_m || fcnt <= 3'd1) begin
            state_nxt = RUN;
            fcnt_nxt  = 3'd0;
          end else begin
            fcnt_nxt = fcnt - 3'd1;
          end
        end
      end
      default: begin
        state_nxt = RUN;
        fcnt_nxt  = 3'd0;
      end
    endcase
    if (rst) begin
      stall_f = 1'b0; stall_d = 1'b0; stall_e = 1'b0; stall_m = 1'b0;
      flush_d = 1'b0; flush_e = 1'b0; flush_w = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      fcnt  <= 3'd0;
    end else begin
      state <= state_nxt;
      fcnt  <= fcnt_nxt;
    end
  end

  assign hz.fwd_a_e = fwd_a;
  assign hz.fwd_b_e = fwd_b;
  assign hz.fwd_c_e = fwd_c;
  assign hz.stall_f = stall_f;
  assign hz.stall_d = stall_d;
  assign hz.stall_e = stall_e;
  assign hz.stall_m = stall_m;
  assign hz.flush_d = flush_d;
  assign hz.flush_e = flush_e;
  assign hz.flush_w = flush_w;

`ifdef HAZARD_PERF_EN
  logic [15:0] stall_cnt, flush_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= 16'd0;
      flush_cnt <= 16'd0;
    end else begin
      if (stall_d && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
      if (flush_e && flush_cnt != 16'hFFFF) flush_cnt <= flush_cnt + 16'd1;
    end
  end

  assign hz.stall_count = stall_cnt;
  assign hz.flush_count = flush_cnt;
`else
  // counters absent in the default build
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: per-cycle behavioural model plus directed literal checks.
module tb_hazard_ctrl;
  localparam int FC = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.REG_BITS(4)) hz();
  hazard_ctrl #(.FLUSH_CYCLES(FC), .REG_BITS(4)) dut (.clk(clk), .rst(rst), .hz(hz));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w}
  wire [6:0] ctl = {hz.stall_f, hz.stall_d, hz.stall_e, hz.stall_m, hz.flush_d, hz.flush_e, hz.flush_w};
  wire [5:0] fwd = {hz.fwd_a_e, hz.fwd_b_e, hz.fwd_c_e};

  localparam logic [6:0] C_MEM = 7'b1111001;
  localparam logic [6:0] C_FL  = 7'b0000110;
  localparam logic [6:0] C_LD  = 7'b1100010;

  // model: waiting on memory, and number of flush cycles still owed
  bit m_wait;
  int m_fleft;
  int m_stall_cnt, m_flush_cnt;

  function automatic logic [1:0] exp_fwd(input logic [3:0] ra);
    if (hz.reg_write_m && hz.wa_m == ra) return 2'b10;
    if (hz.reg_write_w && hz.wa_w == ra) return 2'b01;
    return 2'b00;
  endfunction

  always @(negedge clk) begin : model
    logic [6:0] e;
    logic [5:0] f;
    bit ld, memstall;
    e = 7'd0;
    f = 6'd0;
    if (rst) begin
      m_wait = 0; m_fleft = 0; m_stall_cnt = 0; m_flush_cnt = 0;
    end else begin
      f = {exp_fwd(hz.ra1_e), exp_fwd(hz.ra2_e), exp_fwd(hz.ra3_e)};
      ld = hz.mem_reg_e && hz.reg_write_e &&
           ((hz.use1_d && hz.ra1_d == hz.wa_e) || (hz.use2_d && hz.ra2_d == hz.wa_e) ||
            (hz.use3_d && hz.ra3_d == hz.wa_e));
      memstall = m_wait ? !hz.mem_ready : (hz.mem_access_m && !hz.mem_ready);
      if (memstall) begin
        e = C_MEM; m_wait = 1; m_fleft = 0;
      end else begin
        m_wait = 0;
        if (hz.branch_taken_m) m_fleft = FC;
        if (m_fleft > 0) begin
          e = C_FL; m_fleft--;
        end else if (ld) e = C_LD;
      end
    end
    chk("model_ctl", 32'(ctl), 32'(e));
    chk("model_fwd", 32'(fwd), 32'(f));
`ifdef HAZARD_PERF_EN
    chk("model_stall_count", 32'(hz.stall_count), 32'(m_stall_cnt));
    chk("model_flush_count", 32'(hz.flush_count), 32'(m_flush_cnt));
    if (e[5] && m_stall_cnt < 65535) m_stall_cnt++;
    if (e[1] && m_flush_cnt < 65535) m_flush_cnt++;
`endif
  end

  task automatic idle();
    hz.ra1_d = 4'd0; hz.ra2_d = 4'd0; hz.ra3_d = 4'd0;
    hz.use1_d = 1'b0; hz.use2_d = 1'b0; hz.use3_d = 1'b0;
    hz.ra1_e = 4'd0; hz.ra2_e = 4'd0; hz.ra3_e = 4'd0;
    hz.wa_e = 4'd0; hz.wa_m = 4'd0; hz.wa_w = 4'd0;
    hz.reg_write_e = 1'b0; hz.reg_write_m = 1'b0; hz.reg_write_w = 1'b0;
    hz.mem_reg_e = 1'b0; hz.branch_taken_m = 1'b0;
    hz.mem_access_m = 1'b0; hz.mem_ready = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    hz.reg_write_m = 1'b1; hz.wa_m = 4'd3; hz.ra1_e = 4'd3;
    #2;
    chk("rst_ctl", 32'(ctl), 32'd0);
    chk("rst_fwd", 32'(fwd), 32'd0);
    tick(); tick();
    rst = 1'b0;
    idle();

    // forwarding priority per port, other ports point elsewhere
    for (int p = 0; p < 3; p++) begin
      hz.ra1_e = (p == 0) ? 4'd3 : 4'd7;
      hz.ra2_e = (p == 1) ? 4'd3 : 4'd7;
      hz.ra3_e = (p == 2) ? 4'd3 : 4'd7;
      hz.wa_m = 4'd3; hz.wa_w = 4'd3;
      hz.reg_write_m = 1'b1; hz.reg_write_w = 1'b1;
      smp(); chk("fwd_m_prio", 32'(fwd), 32'(6'b100000 >> (2 * p)));
      tick(); hz.reg_write_m = 1'b0;
      smp(); chk("fwd_w", 32'(fwd), 32'(6'b010000 >> (2 * p)));
      tick(); hz.reg_write_w = 1'b0;
      smp(); chk("fwd_rf", 32'(fwd), 32'd0);
      tick();
    end
    idle();

    // load-use: one bubble, then the load moves on
    hz.mem_reg_e = 1'b1; hz.reg_write_e = 1'b1; hz.wa_e = 4'd5;
    hz.ra2_d = 4'd5; hz.use2_d = 1'b1;
    smp(); chk("ldu_first", 32'(ctl), 32'(C_LD));
    tick(); hz.mem_reg_e = 1'b0; hz.wa_e = 4'd9;
    smp(); chk("ldu_after", 32'(ctl), 32'd0);
    tick(); hz.mem_reg_e = 1'b1; hz.wa_e = 4'd5; hz.use2_d = 1'b0;
    smp(); chk("ldu_unused", 32'(ctl), 32'd0);
    tick(); idle();

    // single branch pulse
    hz.branch_taken_m = 1'b1;
    smp(); chk("br_c1", 32'(ctl), 32'(C_FL));
    tick(); hz.branch_taken_m = 1'b0;
    smp(); chk("br_c2", 32'(ctl), 32'(C_FL));
    tick();
    smp(); chk("br_done", 32'(ctl), 32'd0);
    tick();

    // re-trigger during BFLUSH
    hz.branch_taken_m = 1'b1;
    smp(); chk("rt_c1", 32'(ctl), 32'(C_FL));
    tick();
    smp(); chk("rt_c2", 32'(ctl), 32'(C_FL));
    tick(); hz.branch_taken_m = 1'b0;
    smp(); chk("rt_c3", 32'(ctl), 32'(C_FL));
    tick();
    smp(); chk("rt_done", 32'(ctl), 32'd0);
    tick();

    // memory wait with branch held: flush starts on the release cycle
    hz.mem_access_m = 1'b1; hz.mem_ready = 1'b0; hz.branch_taken_m = 1'b1;
    for (int i = 0; i < 3; i++) begin
      smp(); chk("mw_stall", 32'(ctl), 32'(C_MEM));
      tick();
    end
    hz.mem_ready = 1'b1;
    smp(); chk("mw_rel_flush", 32'(ctl), 32'(C_FL));
    tick(); idle();
    smp(); chk("mw_flush2", 32'(ctl), 32'(C_FL));
    tick();
    smp(); chk("mw_done", 32'(ctl), 32'd0);
    tick();

    // plain memory wait released by mem_ready
    hz.mem_access_m = 1'b1;
    for (int i = 0; i < 3; i++) begin
      smp(); chk("mw2_stall", 32'(ctl), 32'(C_MEM));
      tick();
    end
    hz.mem_ready = 1'b1;
    smp(); chk("mw2_release", 32'(ctl), 32'd0);
    tick(); idle();

    // memory wait preempts remaining flush cycles
    hz.branch_taken_m = 1'b1;
    smp(); chk("pre_flush", 32'(ctl), 32'(C_FL));
    tick(); hz.branch_taken_m = 1'b0; hz.mem_access_m = 1'b1;
    smp(); chk("pre_stall", 32'(ctl), 32'(C_MEM));
    tick(); hz.mem_ready = 1'b1;
    smp(); chk("pre_release", 32'(ctl), 32'd0);
    tick(); idle();
    smp(); chk("pre_no_residual", 32'(ctl), 32'd0);
    tick();

    // asynchronous reset in the middle of MEMWAIT
    hz.mem_access_m = 1'b1;
    tick();
    smp(); chk("ar_waiting", 32'(ctl), 32'(C_MEM));
    #2 rst = 1'b1;
    #1 chk("ar_async_zero", 32'(ctl), 32'd0);
    idle();
    hz.reg_write_w = 1'b1; hz.wa_w = 4'd2; hz.ra2_e = 4'd2;
    tick(); tick();
    rst = 1'b0;
    smp(); chk("ar_run_ctl", 32'(ctl), 32'd0);
    chk("ar_run_fwd", 32'(fwd), 32'(6'b000100));
    tick(); idle();
    smp(); chk("ar_no_residual", 32'(ctl), 32'd0);
    tick();

`ifdef HAZARD_PERF_EN
    hz.mem_access_m = 1'b1;
    repeat (70000) tick();
    hz.mem_ready = 1'b1;
    tick(); idle();
    hz.branch_taken_m = 1'b1;
    tick(); hz.branch_taken_m = 1'b0;
    tick();
    hz.mem_reg_e = 1'b1; hz.reg_write_e = 1'b1; hz.wa_e = 4'd4;
    hz.ra1_d = 4'd4; hz.use1_d = 1'b1;
    tick(); idle();
    smp();
    chk("perf_stall_sat", 32'(hz.stall_count), 32'h0000FFFF);
    chk("perf_flush_exact", 32'(hz.flush_count), 32'd3);
    tick();
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
